// File: rtl/cpu_control_unit.sv
// Hardwired control unit: a two-byte fetch followed by a one-cycle decode/execute.
// Every control output is combinational from State, IROut, Flags and Reset.
module cpu_control_unit #(
  parameter logic [2:0] ADDR_CLR = 3'b011,
  parameter logic [2:0] LOAD     = 3'b010,
  parameter logic [2:0] INC      = 3'b001
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {FETCH_L = 2'b00, FETCH_H = 2'b01, EXEC = 2'b10, HALT = 2'b11} state_t;

  state_t      r_state, w_next;
  logic [5:0]  w_opc;
  logic [1:0]  w_rx, w_ra, w_rb;
  logic [3:0]  w_rx_oh;
  logic        w_z;
  logic        w_unused;

  assign w_opc    = IROut[15:10];
  assign w_rx     = IROut[9:8];
  assign w_ra     = IROut[5:4];
  assign w_rb     = IROut[3:2];
  assign w_z      = Flags[3];
  // RegSel bit 3 is R1, so Rx = 0 maps to the MSB.
  assign w_rx_oh  = 4'b1000 >> w_rx;
  assign w_unused = ^{IROut[7:6], IROut[1:0], Flags[2:0]};
  assign State    = r_state;

  always_ff @(posedge Clock) begin
    if (!Reset) r_state <= FETCH_L;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 3'b000;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;

    if (!Reset) begin
      // Reset overrides the state decode and clears every register.
      ARF_RegSel = 3'b111;
      ARF_FunSel = ADDR_CLR;
      RF_RegSel  = 4'b1111;
      RF_ScrSel  = 4'b1111;
      RF_FunSel  = ADDR_CLR;
    end else begin
      unique case (r_state)
        FETCH_L, FETCH_H: begin
          ARF_OutDSel = 2'b00;
          Mem_CS      = 1'b0;
          IR_Write    = 1'b1;
          IR_LH       = (r_state == FETCH_H);
          ARF_RegSel  = 3'b100;
          ARF_FunSel  = INC;
          w_next      = (r_state == FETCH_L) ? FETCH_H : EXEC;
        end
        EXEC: begin
          w_next = FETCH_L;
          case (w_opc)
            6'h00, 6'h01: begin
              if (w_opc == 6'h00 || !w_z) begin
                MuxBSel    = 2'b11;
                ARF_RegSel = 3'b100;
                ARF_FunSel = LOAD;
              end
            end
            6'h02: begin
              MuxASel   = 2'b11;
              RF_FunSel = LOAD;
              RF_RegSel = w_rx_oh;
            end
            6'h03: begin
              RF_OutASel = {1'b0, w_ra};
              RF_OutBSel = {1'b0, w_rb};
              ALU_FunSel = 5'b10100;
              ALU_WF     = 1'b1;
              MuxASel    = 2'b00;
              RF_FunSel  = LOAD;
              RF_RegSel  = w_rx_oh;
            end
            6'h04: begin
              RF_OutASel  = {1'b0, w_rx};
              ALU_FunSel  = 5'b10000;
              MuxCSel     = 1'b0;
              ARF_OutDSel = 2'b01;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
            end
            6'h05: begin
              ARF_OutDSel = 2'b01;
              Mem_CS      = 1'b0;
              MuxASel     = 2'b10;
              RF_FunSel   = LOAD;
              RF_RegSel   = w_rx_oh;
            end
            6'h3F:   w_next = HALT;
            default: ;
          endcase
        end
        HALT:    w_next = HALT;
        default: w_next = FETCH_L;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: a vector table walked through full
// fetch/exec cycles, plus hand sequences for reset and HALT corner cases.
module tb_cpu_control_unit;

  typedef struct packed {
    logic [2:0] rf_a, rf_b, rf_fun;
    logic [3:0] rf_reg, rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] arf_c, arf_d;
    logic [2:0] arf_fun, arf_reg;
    logic       ir_lh, ir_wr, mem_wr, mem_cs;
    logic [1:0] muxa, muxb;
    logic       muxc;
  } outs_t;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [3:0]  flags;
    outs_t       exp;
    logic [1:0]  nxt;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] IROut = 16'h0000;
  logic [3:0]  Flags = 4'h0;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_FunSel, ARF_RegSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxCSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel, State;

  int n_cmp = 0;
  int n_bad = 0;

  outs_t act, IDLE, FETCH_L_O, FETCH_H_O, RST_O;
  vec_t  vt [0:10];

  cpu_control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .Flags(Flags),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .State(State)
  );

  always #5 Clock = ~Clock;

  assign act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel,
                ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH,
                IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel};

  task automatic check_out(input string name, input outs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: outputs got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    n_cmp++;
    if (State !== exp) begin
      n_bad++;
      $display("FAIL %s: State got %b expected %b", name, State, exp);
    end
  endtask

  // Advance one clock and settle at the following falling edge.
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    IDLE        = '0;
    IDLE.mem_cs = 1'b1;

    FETCH_L_O         = IDLE;
    FETCH_L_O.mem_cs  = 1'b0;
    FETCH_L_O.ir_wr   = 1'b1;
    FETCH_L_O.arf_reg = 3'b100;
    FETCH_L_O.arf_fun = 3'b001;
    FETCH_H_O         = FETCH_L_O;
    FETCH_H_O.ir_lh   = 1'b1;

    RST_O         = IDLE;
    RST_O.arf_reg = 3'b111;
    RST_O.arf_fun = 3'b011;
    RST_O.rf_reg  = 4'b1111;
    RST_O.rf_scr  = 4'b1111;
    RST_O.rf_fun  = 3'b011;

    for (int i = 0; i <= 10; i++) begin
      vt[i].exp   = IDLE;
      vt[i].flags = 4'h0;
      vt[i].nxt   = 2'b00;
    end
    vt[0].name = "movi_r3";  vt[0].ir = 16'h0A85;
    vt[0].exp.muxa = 2'b11; vt[0].exp.rf_fun = 3'b010; vt[0].exp.rf_reg = 4'b0010;
    vt[1].name = "bne_z1";   vt[1].ir = 16'h0420; vt[1].flags = 4'b1000;
    vt[2].name = "bne_z0";   vt[2].ir = 16'h0420;
    vt[2].exp.muxb = 2'b11; vt[2].exp.arf_reg = 3'b100; vt[2].exp.arf_fun = 3'b010;
    vt[3].name = "bne_z0_cno"; vt[3].ir = 16'h0420; vt[3].flags = 4'b0111;
    vt[3].exp = vt[2].exp;
    vt[4].name = "add";      vt[4].ir = 16'h0D24;
    vt[4].exp.rf_a = 3'b010; vt[4].exp.rf_b = 3'b001; vt[4].exp.alu_fun = 5'b10100;
    vt[4].exp.alu_wf = 1'b1; vt[4].exp.rf_fun = 3'b010; vt[4].exp.rf_reg = 4'b0100;
    vt[5].name = "bra";      vt[5].ir = 16'h00FF; vt[5].flags = 4'b1000;
    vt[5].exp = vt[2].exp;
    vt[6].name = "str_r4";   vt[6].ir = 16'h1300;
    vt[6].exp.rf_a = 3'b011; vt[6].exp.alu_fun = 5'b10000; vt[6].exp.arf_d = 2'b01;
    vt[6].exp.mem_cs = 1'b0; vt[6].exp.mem_wr = 1'b1;
    vt[7].name = "ldr_r1";   vt[7].ir = 16'h1400;
    vt[7].exp.arf_d = 2'b01; vt[7].exp.mem_cs = 1'b0; vt[7].exp.muxa = 2'b10;
    vt[7].exp.rf_fun = 3'b010; vt[7].exp.rf_reg = 4'b1000;
    vt[8].name = "nop_06";   vt[8].ir = 16'h1800;
    vt[9].name = "nop_3e";   vt[9].ir = 16'hFBFF;
    vt[10].name = "movi_r4"; vt[10].ir = 16'h0B00;
    vt[10].exp.muxa = 2'b11; vt[10].exp.rf_fun = 3'b010; vt[10].exp.rf_reg = 4'b0001;

    // Reset held low for two edges; clear codes must be driven throughout.
    @(negedge Clock);
    check_out("rst_outputs_c0", RST_O);
    step();
    check_state("rst_state", 2'b00);
    check_out("rst_outputs_c1", RST_O);
    step();
    Reset = 1'b1;
    #1;
    check_state("release_state", 2'b00);
    check_out("first_fetch_l", FETCH_L_O);

    for (int i = 0; i <= 10; i++) begin
      IROut = vt[i].ir;
      Flags = vt[i].flags;
      #1;
      check_state({vt[i].name, "_st_fl"}, 2'b00);
      step();
      check_state({vt[i].name, "_st_fh"}, 2'b01);
      check_out({vt[i].name, "_fetch_h"}, FETCH_H_O);
      step();
      check_state({vt[i].name, "_st_ex"}, 2'b10);
      check_out({vt[i].name, "_exec"}, vt[i].exp);
      step();
      check_state({vt[i].name, "_st_next"}, vt[i].nxt);
      check_out({vt[i].name, "_after"}, FETCH_L_O);
    end

    // Reset during FETCH_H kills the IR write in that same cycle.
    IROut = 16'h0A85;
    step();
    check_state("rfh_pre", 2'b01);
    Reset = 1'b0;
    #1;
    check_out("rfh_outputs", RST_O);
    step();
    check_state("rfh_state", 2'b00);
    Reset = 1'b1;

    // Reset during EXEC returns to FETCH_L instead of continuing.
    step();
    step();
    check_state("rex_pre", 2'b10);
    Reset = 1'b0;
    #1;
    check_out("rex_outputs", RST_O);
    step();
    check_state("rex_state", 2'b00);
    Reset = 1'b1;

    // HALT: idle and stuck for 10 cycles, left only by reset.
    IROut = 16'hFC00;
    step();
    step();
    check_state("halt_exec_st", 2'b10);
    check_out("halt_exec", IDLE);
    for (int c = 0; c < 10; c++) begin
      step();
      check_state("halt_hold_st", 2'b11);
      check_out("halt_hold", IDLE);
    end
    Reset = 1'b0;
    #1;
    check_out("halt_rst_outputs", RST_O);
    step();
    check_state("halt_rst_state", 2'b00);
    Reset = 1'b1;
    #1;
    check_out("halt_refetch", FETCH_L_O);
    step();
    check_state("halt_refetch_h", 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 Parameter ADDR_CLR, default 3'b011; ARF/RF FunSel code for clear.
REQ-002 Parameter LOAD, default 3'b010; ARF/RF FunSel code for load. Parameter INC, default 3'b001; ARF FunSel code for increment.
REQ-003 Ports:
- Clock  in  1  sole clock; rising edge.
- Reset  in  1  synchronous, active-low reset.
- IROut  in  16  instruction register contents.
- Flags  in  4  ALU flags {Z,C,N,O}; Z = Flags[3].
- RF_OutASel, RF_OutBSel, RF_FunSel  out  3 each  register file controls.
- RF_RegSel, RF_ScrSel  out  4 each  one-hot active-high enables; RF_RegSel[3:0] = R1..R4.
- ALU_FunSel  out  5  ALU operation. ALU_WF  out  1  flag write enable.
- ARF_OutCSel, ARF_OutDSel  out  2 each  00 = PC, 01 = AR, 10 = SP.
- ARF_FunSel  out  3. ARF_RegSel  out  3  one-hot {PC,AR,SP}.
- IR_LH, IR_Write  out  1 each  IR byte select (0 = low) and write enable.
- Mem_WR, Mem_CS  out  1 each  1 = write; Mem_CS active-low.
- MuxASel, MuxBSel  out  2 each. MuxCSel  out  1.
- State  out  2  00 FETCH_L, 01 FETCH_H, 10 EXEC, 11 HALT.

Function
REQ-004 Outputs are combinational from State, IROut and Flags.
- Idle values: all RegSel/ScrSel = 0, IR_Write = 0, ALU_WF = 0, Mem_CS = 1, Mem_WR = 0.
- Every output not named in a state is at its idle value; all other selects are 0.
REQ-005 FETCH_L drives:
- ARF_OutDSel = 00, Mem_CS = 0, Mem_WR = 0.
- IR_Write = 1, IR_LH = 0.
- ARF_RegSel = 100, ARF_FunSel = INC.
- Next state: FETCH_H.
REQ-006 FETCH_H drives the same outputs with IR_LH = 1; next state EXEC.
REQ-007 EXEC decodes opcode = IROut[15:10], Rx = IROut[9:8], Ra = IROut[5:4], Rb = IROut[3:2]. Next state is FETCH_L unless stated otherwise.
REQ-008 Opcode 0x00 BRA: MuxBSel = 11, ARF_RegSel = 100, ARF_FunSel = LOAD (PC <- sign-extended IROut[7:0]).
REQ-009 Opcode 0x01 BNE: performs BRA when Z = 0; when Z = 1, all outputs are idle.
REQ-010 Opcode 0x02 MOVI: MuxASel = 11, RF_FunSel = LOAD, RF_RegSel = one-hot(Rx).
REQ-011 Opcode 0x03 ADD:
- RF_OutASel = {0,Ra}, RF_OutBSel = {0,Rb}.
- ALU_FunSel = 10100, ALU_WF = 1.
- MuxASel = 00, RF_FunSel = LOAD, RF_RegSel = one-hot(Rx).
REQ-012 Opcode 0x04 STR:
- RF_OutASel = {0,Rx}, ALU_FunSel = 10000 (pass A), MuxCSel = 0.
- ARF_OutDSel = 01, Mem_CS = 0, Mem_WR = 1.
REQ-013 Opcode 0x05 LDR:
- ARF_OutDSel = 01, Mem_CS = 0, Mem_WR = 0.
- MuxASel = 10, RF_FunSel = LOAD, RF_RegSel = one-hot(Rx).
REQ-014 Opcode 0x3F HALT: outputs idle; next state HALT. HALT holds all outputs idle and is exited only by reset.
REQ-015 Any other opcode executes as a NOP: outputs idle, return to FETCH_L.
REQ-016 Every non-HALT instruction takes exactly 3 cycles; PC advances by 2 per instruction before EXEC.
REQ-017 Flags are sampled only in EXEC of BNE, combinationally, in the same cycle.

Reset
REQ-018 Reset = 0 at any rising edge sets State = FETCH_L, including mid-fetch, mid-EXEC and from HALT.
REQ-019 While Reset = 0, outputs override State:
- ARF_RegSel = 111, ARF_FunSel = ADDR_CLR.
- RF_RegSel = 1111, RF_ScrSel = 1111, RF_FunSel = ADDR_CLR.
- All other outputs idle.
REQ-020 The first FETCH_L occurs in the first cycle after Reset returns to 1.

Verification
REQ-021 Reset low for 2 cycles, then release -> State 00 on release; clear codes driven while low; IR_Write = 1, IR_LH = 0 in the first cycle after release.
REQ-022 IROut = 0x0A85 (MOVI R3, 0x85) in EXEC -> MuxASel = 11, RF_RegSel = 0010, RF_FunSel = 010; State sequence 00, 01, 10, 00.
REQ-023 IROut = 0x0420 with Flags = 1000 -> idle outputs in EXEC; with Flags = 0000 -> MuxBSel = 11, ARF_RegSel = 100, ARF_FunSel = 010.
REQ-024 IROut = 0x0D24 (ADD R2 = R3 + R2) -> OutASel = 010, OutBSel = 001, ALU_FunSel = 10100, ALU_WF = 1, RF_RegSel = 0100.
REQ-025 IROut = 0xFC00 -> State = 11 with idle outputs for 10 cycles; Reset pulse -> State = 00.
REQ-026 Reset asserted during FETCH_H -> IR_Write = 0 that cycle; State = 00 on the next edge.
